// File: rtl/pc_fetch_unit_pkg.sv
// rtl/pc_fetch_unit_pkg.sv - shared encodings for the fetch stage
package pc_fetch_unit_pkg;

  typedef enum logic {
    ST_RUN        = 1'b0,
    ST_REDIR_WAIT = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/pc_adder.sv
// rtl/pc_adder.sv - combinational PC + 4 incrementer, wraps modulo 2^XLEN
module pc_adder #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_plus4
);

  assign pc_plus4 = pc + XLEN'(4);

endmodule

// File: rtl/pc_fetch_unit.sv
// rtl/pc_fetch_unit.sv - fetch PC owner: redirects, stalls, busy-memory parking
module pc_fetch_unit
  import pc_fetch_unit_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic            PC_SEL,
  input  logic [XLEN-1:0] BRANCH_TARGET,
  input  logic            STALL,
  input  logic            IMEM_BUSY,
  output logic [XLEN-1:0] PC,
  output logic [XLEN-1:0] PC_PLUS4,
  output logic            IMEM_READ,
  output logic            FLUSH,
  output logic            MISALIGN
);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] saved_q, saved_d;
  logic [XLEN-1:0] pc_inc;
  logic [XLEN-1:0] target_aligned;
  logic            misalign_q, misalign_d;
  logic            imem_read_q;

  pc_adder #(.XLEN(XLEN)) u_pc_adder (
    .pc       (pc_q),
    .pc_plus4 (pc_inc)
  );

  assign target_aligned = {BRANCH_TARGET[XLEN-1:2], 2'b00};

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_q     <= ST_RUN;
      pc_q        <= RESET_PC;
      saved_q     <= '0;
      misalign_q  <= 1'b0;
      imem_read_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      saved_q     <= saved_d;
      misalign_q  <= misalign_d;
      imem_read_q <= 1'b1;
    end
  end

  // A redirect outranks STALL: a resolved branch beats a load-use freeze.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    saved_d    = saved_q;
    misalign_d = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (PC_SEL) begin
          misalign_d = |BRANCH_TARGET[1:0];
          if (IMEM_BUSY) begin
            saved_d = target_aligned;
            state_d = ST_REDIR_WAIT;
          end else begin
            pc_d = target_aligned;
          end
        end else if (!(STALL || IMEM_BUSY)) begin
          pc_d = pc_inc;
        end
      end
      ST_REDIR_WAIT: begin
        if (!IMEM_BUSY) begin
          pc_d    = saved_q;
          state_d = ST_RUN;
        end
      end
    endcase
  end

  always_comb begin
    FLUSH = (state_q == ST_REDIR_WAIT) || ((state_q == ST_RUN) && PC_SEL);
  end

  assign PC        = pc_q;
  assign PC_PLUS4  = pc_inc;
  assign IMEM_READ = imem_read_q;
  assign MISALIGN  = misalign_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb/tb_pc_fetch_unit.sv - self-checking bench for pc_fetch_unit
module tb_pc_fetch_unit;

  localparam int          XLEN     = 32;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        CLK = 1'b0;
  logic        RESET = 1'b0;
  logic        PC_SEL = 1'b0;
  logic [31:0] BRANCH_TARGET = '0;
  logic        STALL = 1'b0;
  logic        IMEM_BUSY = 1'b0;
  logic [31:0] PC, PC_PLUS4;
  logic        IMEM_READ, FLUSH, MISALIGN;

  int checks = 0;
  int failures = 0;

  pc_fetch_unit #(.XLEN(XLEN), .RESET_PC(RESET_PC)) dut (
    .CLK           (CLK),
    .RESET         (RESET),
    .PC_SEL        (PC_SEL),
    .BRANCH_TARGET (BRANCH_TARGET),
    .STALL         (STALL),
    .IMEM_BUSY     (IMEM_BUSY),
    .PC            (PC),
    .PC_PLUS4      (PC_PLUS4),
    .IMEM_READ     (IMEM_READ),
    .FLUSH         (FLUSH),
    .MISALIGN      (MISALIGN)
  );

  always #5 CLK = ~CLK;

  // Reference: a pending redirect is simply "a parked address, or none".
  logic [31:0] m_pc = RESET_PC;
  logic [31:0] m_parked = '0;
  bit          m_parked_valid = 0;
  bit          m_read = 0;
  bit          m_misalign = 0;
  bit          m_live = 0;

  always @(posedge CLK) begin
    if (!RESET) begin
      m_pc = RESET_PC;
      m_parked = '0;
      m_parked_valid = 0;
      m_read = 0;
      m_misalign = 0;
      m_live = 1;
    end else begin
      m_read = 1;
      m_misalign = 0;
      if (m_parked_valid) begin
        if (!IMEM_BUSY) begin
          m_pc = m_parked;
          m_parked_valid = 0;
        end
      end else if (PC_SEL) begin
        m_misalign = (BRANCH_TARGET % 4) != 0;
        if (IMEM_BUSY) begin
          m_parked = BRANCH_TARGET - (BRANCH_TARGET % 4);
          m_parked_valid = 1;
        end else begin
          m_pc = BRANCH_TARGET - (BRANCH_TARGET % 4);
        end
      end else if (!STALL && !IMEM_BUSY) begin
        m_pc = m_pc + 32'd4;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge CLK) begin
    if (m_live) begin
      check("model_pc", PC, m_pc);
      check("model_pc_plus4", PC_PLUS4, m_pc + 32'd4);
      check("model_imem_read", {31'd0, IMEM_READ}, {31'd0, m_read});
      check("model_flush", {31'd0, FLUSH}, {31'd0, m_parked_valid || PC_SEL});
      check("model_misalign", {31'd0, MISALIGN}, {31'd0, m_misalign});
    end
  end

  task automatic drive(input logic rst, input logic sel, input logic [31:0] tgt,
                       input logic stl, input logic bsy);
    RESET = rst;
    PC_SEL = sel;
    BRANCH_TARGET = tgt;
    STALL = stl;
    IMEM_BUSY = bsy;
    #1;
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    drive(0, 0, 0, 0, 0);
    repeat (2) step();
    check("reset_pc", PC, RESET_PC);
    check("reset_imem_read", {31'd0, IMEM_READ}, 32'd0);
    check("reset_misalign", {31'd0, MISALIGN}, 32'd0);

    drive(1, 0, 0, 0, 0);
    step();
    check("seq_pc_4", PC, 32'h4);
    check("seq_imem_read", {31'd0, IMEM_READ}, 32'd1);
    step(); check("seq_pc_8", PC, 32'h8);
    step(); check("seq_pc_c", PC, 32'hC);
    check("seq_plus4", PC_PLUS4, 32'h10);
    step(); check("seq_pc_10", PC, 32'h10);

    drive(1, 1, 32'h40, 0, 0);
    check("branch_flush_same_cycle", {31'd0, FLUSH}, 32'd1);
    step(); check("branch_pc_40", PC, 32'h40);
    drive(1, 0, 0, 0, 0);
    step(); check("branch_pc_44", PC, 32'h44);

    drive(1, 1, 32'h80, 1, 0);
    step(); check("redirect_over_stall", PC, 32'h80);
    drive(1, 0, 0, 1, 0);
    for (int i = 0; i < 3; i++) begin
      step(); check("stall_hold", PC, 32'h80);
    end

    drive(1, 1, 32'h200, 0, 1);
    check("busy_flush_0", {31'd0, FLUSH}, 32'd1);
    step();
    drive(1, 0, 0, 0, 1);
    check("busy_flush_1", {31'd0, FLUSH}, 32'd1);
    check("busy_pc_held_1", PC, 32'h80);
    step();
    check("busy_flush_2", {31'd0, FLUSH}, 32'd1);
    check("busy_pc_held_2", PC, 32'h80);
    drive(1, 0, 0, 0, 0);
    step();
    check("busy_release_pc", PC, 32'h200);
    check("busy_release_flush", {31'd0, FLUSH}, 32'd0);

    drive(1, 1, 32'h103, 0, 0);
    step();
    check("misalign_pc", PC, 32'h100);
    check("misalign_pulse", {31'd0, MISALIGN}, 32'd1);
    drive(1, 0, 0, 0, 0);
    step();
    check("misalign_clear", {31'd0, MISALIGN}, 32'd0);
    check("misalign_next_pc", PC, 32'h104);

    drive(1, 1, 32'hFFFF_FFFC, 0, 0);
    step();
    check("wrap_top", PC, 32'hFFFF_FFFC);
    check("wrap_plus4", PC_PLUS4, 32'h0);
    drive(1, 0, 0, 0, 0);
    step(); check("wrap_zero", PC, 32'h0);

    drive(1, 1, 32'h300, 0, 1);
    step();
    drive(0, 0, 0, 0, 1);
    step();
    check("reset_wait_pc", PC, RESET_PC);
    check("reset_wait_flush", {31'd0, FLUSH}, 32'd0);
    drive(1, 0, 0, 0, 0);
    for (int i = 1; i <= 4; i++) begin
      step(); check("reset_wait_no_park", PC, RESET_PC + 32'(4 * i));
    end

    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 49) != 0),
            ($urandom_range(0, 3) == 0),
            $urandom(),
            ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 2) == 0));
      step();
    end

    drive(1, 0, 0, 0, 0);
    step();
    @(negedge CLK);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
Program-counter and fetch-control stage directly downstream of bj_detect. Consumes PC_SEL together with the branch/jump target computed in EX, and owns the architectural fetch PC. Drives instruction-memory fetch requests and issues flush requests to the IF/ID and ID/EX pipeline registers. Handles redirects that arrive while instruction memory is busy by parking the target until memory is free.

Parameters:
XLEN, 32, datapath / PC width.
RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports:
CLK  in  1  system clock; all state updates on rising edge.
RESET  in  1  synchronous reset, active-low; sampled on the CLK rising edge.
PC_SEL  in  1  redirect request from bj_detect: 1 = take BRANCH_TARGET.
BRANCH_TARGET  in  XLEN  redirect target from the EX-stage ALU.
STALL  in  1  hazard-unit freeze: hold the PC.
IMEM_BUSY  in  1  instruction memory cannot accept a new address this cycle.
PC  out  XLEN  current fetch address (registered).
PC_PLUS4  out  XLEN  PC+4, forwarded to IF/ID for link values (combinational from PC).
IMEM_READ  out  1  fetch request (registered).
FLUSH  out  1  squash younger instructions in IF/ID and ID/EX.
MISALIGN  out  1  one-cycle pulse: redirect target had bits [1:0] != 0 (registered).

Behaviour:
- Reset (RESET==0 at a rising edge) produces the following state: PC=RESET_PC; state=RUN; saved_target=0; IMEM_READ=0; MISALIGN=0. Reset overrides all other inputs. Reset during REDIR_WAIT discards the parked target.
- IMEM_READ becomes 1 on the first edge with RESET==1 and stays 1 thereafter.
- State machine has 2 states, RUN and REDIR_WAIT.
- RUN, priority order (first match wins):
  1. PC_SEL=1 and IMEM_BUSY=0: PC <= {BRANCH_TARGET[XLEN-1:2],2'b00}; stay in RUN.
  2. PC_SEL=1 and IMEM_BUSY=1: saved_target <= aligned target; PC held; go to REDIR_WAIT.
  3. STALL=1 or IMEM_BUSY=1: PC held.
  4. Otherwise: PC <= PC+4.
- A redirect overrides STALL, because a resolved branch beats a load-use freeze.
- REDIR_WAIT:
  - PC held while IMEM_BUSY=1.
  - When IMEM_BUSY=0: PC <= saved_target and go to RUN.
  - PC_SEL and STALL are ignored in this state; the pipeline is already flushed, so no new branch can resolve.
- FLUSH is combinational: 1 when (state==RUN && PC_SEL) or state==REDIR_WAIT; otherwise 0. Latency from PC_SEL to FLUSH is 0 cycles. Latency from PC_SEL to the new PC is 1 edge when memory is free.
- MISALIGN <= 1 for exactly one cycle after an accepted redirect (cases RUN-1 and RUN-2) whose BRANCH_TARGET[1:0] != 0; otherwise 0.
- Arithmetic: PC+4 is modulo 2^XLEN, so 32'hFFFF_FFFC wraps to 32'h0000_0000 with no flag. PC[1:0] is always 00.
- PC_SEL=0 while the bj_detect encoding is NO is the normal sequential path; no other branch encoding is visible to this block.

Decomposition:
- State encodings (RUN=1'b0, REDIR_WAIT=1'b1) go in the shared encodings include, next to the branch/jump encodings.
- One sub-module, pc_adder: a combinational XLEN-bit +4 adder feeding both PC_PLUS4 and the sequential next-PC mux.

Test Plan:
- Reset and sequential fetch: hold RESET=0 for 2 cycles, then release with STALL=0, IMEM_BUSY=0, PC_SEL=0. Expect IMEM_READ=1 and PC stepping 0x0, 0x4, 0x8, 0xC on successive edges; PC_PLUS4=PC+4 throughout.
- Taken branch: at PC=0x10 assert PC_SEL=1 with BRANCH_TARGET=0x40. Expect FLUSH=1 in the same cycle and PC=0x40 after the edge, then 0x44 next.
- Redirect vs stall: PC_SEL=1, STALL=1, BRANCH_TARGET=0x80. Expect PC=0x80 after the edge. With STALL=1 alone, expect PC held for 3 cycles.
- Redirect while memory busy: IMEM_BUSY=1 for 3 cycles, with PC_SEL=1 and BRANCH_TARGET=0x200 in the first cycle. Expect FLUSH=1 in all 3 cycles and PC unchanged. The edge after IMEM_BUSY falls, expect PC=0x200 and FLUSH=0.
- Misaligned target and wrap: BRANCH_TARGET=0x103 with PC_SEL=1. Expect PC=0x100 and MISALIGN=1 for exactly one cycle. Separately, redirect to 0xFFFF_FFFC, then expect PC=0x0 on the next sequential edge.
- Reset mid-wait: enter REDIR_WAIT parking target 0x300, then drive RESET=0. Expect PC=RESET_PC and FLUSH=0, and after release 0x300 never appears on PC.
